// File: rtl/int_to_fp_converter.sv
// Integer to IEEE-754 double converter.
// Accepts a signed or unsigned WIDTH-bit integer and produces a double, using
// round-toward-zero. Normalisation shifts the magnitude left one bit per cycle
// until its MSB is set, so latency depends on the operand's leading zeros.
// Both sides use valid/ready handshakes, and one conversion is in flight at a time.
module int_to_fp_converter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_data
);

   // A 7-bit count covers the largest shift count (WIDTH-1 = 63).
   localparam int CW = 7;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sign_q, sign_d;
   logic [63:0]      out_data_q, out_data_d;

   logic             in_neg;
   logic [WIDTH-1:0] in_mag;
   logic [WIDTH-1:0] mag_shifted;
   logic [CW-1:0]    cnt_next;

   // Packs a normalised magnitude (MSB set) into a double. The magnitude is
   // left-aligned in 64 bits and the bits below the hidden one are kept.
   // This zero-fills narrow operands and truncates wide ones in a single
   // expression.
   function automatic logic [63:0] build_result(
      input logic             s,
      input logic [WIDTH-1:0] m,
      input logic [CW-1:0]    c
   );
      logic [63:0] ext;
      logic [10:0] e;
      ext = 64'(m) << (64 - WIDTH);
      e   = 11'(1023 + (WIDTH - 1) - int'(c));
      return {s, e, ext[62:11]};
   endfunction

   assign in_neg      = in_signed & in_data[WIDTH-1];
   assign in_mag      = in_neg ? (~in_data + WIDTH'(1)) : in_data;
   assign mag_shifted = mag_q << 1;
   assign cnt_next    = cnt_q + CW'(1);

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = out_data_q;

   // Next-state logic: accept an operand, normalise it, then hold the result for the consumer.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
      state_d    = state_q;
      mag_d      = mag_q;
      cnt_d      = cnt_q;
      sign_d     = sign_q;
      out_data_d = out_data_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d = in_neg;
               mag_d  = in_mag;
               cnt_d  = '0;
               if (in_mag == '0) begin
                  // Zero is always +0.0.
                  sign_d     = 1'b0;
                  out_data_d = 64'h0;
                  state_d    = DONE;
               end else if (in_mag[WIDTH-1]) begin
                  out_data_d = build_result(in_neg, in_mag, '0);
                  state_d    = DONE;
               end else begin
                  state_d = NORM;
               end
            end
         end
         NORM: begin
            mag_d = mag_shifted;
            cnt_d = cnt_next;
            if (mag_shifted[WIDTH-1]) begin
               out_data_d = build_result(sign_q, mag_shifted, cnt_next);
               state_d    = DONE;
            end
         end
         DONE: begin
            // The result stays in out_data_q after the handshake.
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset discards any in-flight conversion.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments make all registers update together from the values they had before the edge.
      if (rst) begin
         state_q    <= IDLE;
         mag_q      <= '0;
         cnt_q      <= '0;
         sign_q     <= 1'b0;
         out_data_q <= 64'h0;
      end else begin
         state_q    <= state_d;
         mag_q      <= mag_d;
         cnt_q      <= cnt_d;
         sign_q     <= sign_d;
         out_data_q <= out_data_d;
      end
   end

endmodule

// File: doc/int_to_fp_converter.md
Name: int_to_fp_converter

Overview:
- Sequential converter from a WIDTH-bit integer (signed or unsigned) to IEEE-754 double precision (1/11/52, bias 1023).
- Produces operands for the double-precision FP adder from integer-unit results; it is the producer end of the FP operand path that the adder consumes.
- Normalisation is iterative, one left-shift per cycle, with valid/ready handshakes on both sides.
- Rounding is round-toward-zero (truncation), matching the adder datapath.

Parameters:
- WIDTH, 64, integer operand width; legal range 2..64.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand present.
- in_ready  output  1  converter can accept an operand.
- in_data  input  WIDTH  integer operand.
- in_signed  input  1  1 = in_data is two's complement; 0 = unsigned. Sampled with in_data.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  64  IEEE-754 double result.

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, out_data=64'h0, internal magnitude/count cleared, in_ready=1.
- FSM states: IDLE, NORM, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE, accept on edge with in_valid&in_ready:
  - sign = in_signed & in_data[WIDTH-1].
  - mag = sign ? (~in_data + 1) : in_data (WIDTH bits).
  - cnt = 0.
  - mag==0: load out_data=64'h0 (sign forced 0, no -0.0); go to DONE.
  - mag[WIDTH-1]==1: build result; go to DONE.
  - Otherwise: go to NORM.
- NORM, each cycle: mag <= mag<<1, cnt <= cnt+1. When the shifted value has MSB=1, the result is built from the shifted value and the FSM goes to DONE on that same edge.
- Shift count: k = number of leading zeros of mag.
- Latency: out_valid rises the cycle after edge E0+k, where E0 is the accept edge (k=0 for zero or MSB set). Maximum k = WIDTH-1.
- Result build:
  - exponent = 1023 + (WIDTH-1) - cnt, 11-bit; no overflow possible for WIDTH≤64.
  - mantissa = normalised mag[WIDTH-2:0], left-aligned into 52 bits.
  - If WIDTH-1 < 52, zero-fill the low bits; if WIDTH-1 > 52, truncate the low bits (no rounding, no sticky).
  - out_data = {sign, exponent, mantissa}.
- Signed minimum (in_signed=1, in_data=1<<(WIDTH-1)): the negation yields the same pattern, MSB set, k=0. Result is exactly -2^(WIDTH-1).
- DONE:
  - out_data is held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE. out_data keeps its last value.
  - No new accept in the same cycle; in_ready=0 in DONE, so a minimum of 1 idle cycle separates results.
- in_valid while not in IDLE is ignored. in_data/in_signed are only sampled on accept, so later changes have no effect.
- rst asserted in NORM or DONE: in-flight conversion is discarded and outputs return to reset values immediately. No result is emitted.
- out_valid never asserts without a preceding accept.

Test Plan:
- WIDTH=64, in_data=1, in_signed=0 -> out_data=64'h3FF0000000000000; out_valid rises exactly 64 cycles after the accept edge (k=63).
- in_data=64'hFFFFFFFFFFFFFFFF: with in_signed=1 -> 64'hBFF0000000000000; with in_signed=0 -> 64'h43EFFFFFFFFFFFFF (truncated, k=0, 1-cycle latency).
- in_data=0 -> 64'h0000000000000000, 1-cycle latency. in_data=64'h8000000000000000: signed -> 64'hC3E0000000000000; unsigned -> 64'h43E0000000000000.
- in_data=64'h0020000000000001, unsigned -> 64'h4340000000000000 (low bit truncated), k=10. in_data=-3 signed -> 64'hC008000000000000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, new in_valid ignored. Raise out_ready -> in_ready=1 the next cycle.
- Assert rst for 1 cycle mid-NORM of in_data=1 -> out_valid=0, out_data=0, in_ready=1 immediately. No stale result appears; the next conversion (in_data=2) -> 64'h4000000000000000.
